// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte/line bundle for the UART transmit framer.
// The master side drives the start strobe, the data byte and the baud tick.
// The slave side (the framer) drives the generator enable and the serial line.
// It also drives the busy and done status flags.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 en;
    logic                 baud_en;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        output en,
        input  baud_en,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        input  en,
        output baud_en,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer driven by the baud generator's one-clock
// en tick. It sends a start bit, then DATA_BITS data bits LSB first, then
// STOP_BITS stop bits. baud_en is held high for the whole frame.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q;
    logic [2:0]           cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;
    logic                 baud_en_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    // Frame sequencer: every state change after the accept happens only on an en tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            baud_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q      <= 1'b1;
                    baud_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                    // en is deliberately ignored here, even when it coincides with a start.
                    if (bus.tx_start) begin
                        shift_q   <= bus.tx_data;
                        cnt_q     <= '0;
                        tx_q      <= 1'b0;
                        baud_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                        par_q     <= ^bus.tx_data;
`endif
                    end
                end
                S_START: begin
                    if (bus.en) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.en) begin
                        if (cnt_q == LAST_DATA) begin
                            cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bus.en) begin
                        tx_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bus.en) begin
                        if (cnt_q == LAST_STOP) begin
                            // Dropping baud_en here gives the generator an idle clock to restart its count.
                            cnt_q     <= '0;
                            baud_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_q      <= 1'b1;
                    baud_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.baud_en = baud_en_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: bench for uart_tx_frame with a baud-generator model and a
// line recorder. Expected frames come from the UART framing rules.
// Set UART_TX_PARITY_EN for both bench and design to exercise parity.
module tb_uart_tx_frame;

    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = 1 + DB + PAR_BITS + SB;

    logic clk;
    logic reset;
    int   div;
    bit   en_inject;
    int   tests;
    int   fails;
    int   done_cnt;
    bit   line_q[$];

    uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

    uart_tx_frame #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud generator model: counts while baud_en is high and ticks every div clocks.
    // At each tick it records the line value of the bit interval just ending.
    initial begin
        int cnt;
        cnt    = 0;
        bus.en = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.baud_en !== 1'b1 || reset) begin
                cnt    = 0;
                bus.en = en_inject;
            end else begin
                cnt++;
                if (cnt >= div) begin
                    cnt    = 0;
                    bus.en = 1'b1;
                    line_q.push_back(bus.tx);
                end else begin
                    bus.en = 1'b0;
                end
            end
        end
    end

    // Done-pulse counter
    initial begin
        done_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_done === 1'b1) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1s; bit k of the word is line bit k.
    function automatic logic [31:0] frame_bits(input logic [7:0] d);
        logic [31:0] w;
        int          idx;
        w   = '0;
        idx = 1;
        for (int i = 0; i < DB; i++) begin
            w[idx] = d[i];
            idx++;
        end
        if (PAR_BITS == 1) begin
            w[idx] = ^d[DB-1:0];
            idx++;
        end
        for (int s = 0; s < SB; s++) begin
            w[idx] = 1'b1;
            idx++;
        end
        return w;
    endfunction

    function automatic logic [31:0] line_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < line_q.size() && i < 32; i++) w[i] = line_q[i];
        return w;
    endfunction

    // Called on a negedge; returns on the negedge right after the accepting edge.
    task automatic start_frame(input logic [7:0] d, input bit inj);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        en_inject    = inj;
        @(negedge clk);
        bus.tx_start = 1'b0;
        en_inject    = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        int limit;
        limit = (NBITS + 2) * div;
        cyc   = 0;
        while (bus.tx_done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/done_seen"}, 32'(bus.tx_done), 32'd1);
    endtask

    // Sends one frame and checks latency, timing, line content and the done pulse; returns in the done cycle.
    task automatic frame_to_done(input string tag, input logic [7:0] d, input bit inj);
        int d0;
        int cyc;
        int tgt;
        line_q.delete();
        d0 = done_cnt;
        start_frame(d, inj);
        check({tag, "/accept{tx,baud_en,busy}"},
              32'({bus.tx, bus.baud_en, bus.tx_busy}), 32'b011);
        wait_done(tag, cyc);
        tgt = NBITS * div;
        check({tag, "/frame_clks_in_range"}, 32'(cyc >= tgt - 1 && cyc <= tgt + 1), 32'd1);
        check({tag, "/done{tx,baud_en,busy}"},
              32'({bus.tx, bus.baud_en, bus.tx_busy}), 32'b100);
        check({tag, "/nbits"}, 32'(line_q.size()), 32'(NBITS));
        check({tag, "/line"}, line_word(), frame_bits(d));
        check({tag, "/done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic done_pulse(input string tag);
        @(negedge clk);
        check({tag, "/done_one_clk"}, 32'(bus.tx_done), 32'd0);
    endtask

    initial begin
        int          d0;
        int          cyc;
        int          k;
        logic [7:0]  rd;
        bit          rinj;

        tests        = 0;
        fails        = 0;
        div          = 16;
        en_inject    = 1'b1;
        reset        = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;

        // Reset held with clock and en toggling
        repeat (4) @(negedge clk);
        check("rst/tx", 32'(bus.tx), 32'd1);
        check("rst/baud_en", 32'(bus.baud_en), 32'd0);
        check("rst/busy", 32'(bus.tx_busy), 32'd0);
        check("rst/done", 32'(bus.tx_done), 32'd0);
        en_inject = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check("rel/outputs{tx,baud_en,busy,done}",
              32'({bus.tx, bus.baud_en, bus.tx_busy, bus.tx_done}), 32'b1000);

        // en while idle is ignored
        en_inject = 1'b1;
        repeat (5) @(negedge clk);
        en_inject = 1'b0;
        check("idle_en/tx", 32'(bus.tx), 32'd1);
        check("idle_en/busy", 32'(bus.tx_busy), 32'd0);
        check("idle_en/no_done", 32'(done_cnt), 32'd0);

        // Full-rate frame 0xA5
        div = 2604;
        frame_to_done("a5", 8'hA5, 1'b0);
`ifdef UART_TX_PARITY_EN
        check("a5/parity_bit", 32'(line_q[1+DB]), 32'd0);
`endif
        done_pulse("a5");

        div = 16;
`ifdef UART_TX_PARITY_EN
        frame_to_done("p01", 8'h01, 1'b0);
        check("p01/parity_bit", 32'(line_q[1+DB]), 32'd1);
        done_pulse("p01");
`endif

        // en and tx_start in the same idle cycle
        frame_to_done("en_start", 8'hC3, 1'b1);
        done_pulse("en_start");

        // Randomized bytes, divisors and coincident en
        for (int n = 0; n < 8; n++) begin
            rd   = 8'($urandom_range(0, 255));
            div  = $urandom_range(6, 24);
            rinj = 1'($urandom_range(0, 1));
            frame_to_done($sformatf("rnd%0d_%02h", n, rd), rd, rinj);
            done_pulse($sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Busy rejection: a second start and data change mid-frame must not disturb the frame
        div = 16;
        line_q.delete();
        d0 = done_cnt;
        start_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (20) @(negedge clk);
        bus.tx_data = 8'h00;
        wait_done("busy", cyc);
        check("busy/line", line_word(), frame_bits(8'h3C));
        repeat (3 * 16) @(negedge clk);
        check("busy/one_done", 32'(done_cnt - d0), 32'd1);
        check("busy/no_second_frame", 32'(line_q.size()), 32'(NBITS));
        check("busy/idle", 32'({bus.tx, bus.tx_busy}), 32'b10);

        // Back-to-back: second start in the done cycle of the first
        frame_to_done("b2b_0f", 8'h0F, 1'b0);
        frame_to_done("b2b_55", 8'h55, 1'b0);
        done_pulse("b2b_55");

        // Reset during data bit 3
        line_q.delete();
        d0 = done_cnt;
        start_frame(8'h81, 1'b0);
        k = 0;
        while (line_q.size() < 4 && k < 10 * div) begin
            @(negedge clk);
            k++;
        end
        check("rstmid/reached_bit3", 32'(line_q.size()), 32'd4);
        repeat (div / 2) @(negedge clk);
        check("rstmid/bit3_value", 32'(bus.tx), 32'(frame_bits(8'h81) >> 4) & 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid/async{tx,baud_en,busy,done}",
              32'({bus.tx, bus.baud_en, bus.tx_busy, bus.tx_done}), 32'b1000);
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3 * div) @(negedge clk);
        check("rstmid/no_done", 32'(done_cnt - d0), 32'd0);
        check("rstmid/line_idle", 32'(bus.tx), 32'd1);
        frame_to_done("after_rst_81", 8'h81, 1'b0);
        done_pulse("after_rst_81");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer that sits directly downstream of the team's baud-rate generator and consumes its one-clock `en` tick.
- Accepts a parallel byte with a start strobe and drives the generator's `baud_en` for the duration of a frame.
- Shifts out start, data (LSB first), optional parity and stop bits on the serial `tx` line.
- System clock is 50 MHz; the generator ticks every 2604 clocks (19200 baud).

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_start  input  1  start strobe; sampled only while idle.
- tx_data  input  DATA_BITS  byte to send; captured on accepted tx_start.
- en  input  1  baud tick from the generator; one clk wide.
- baud_en  output  1  enables the generator; high for the whole frame.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high from the accept cycle until the frame ends.
- tx_done  output  1  one-clock pulse at the end of a frame.

Behaviour:
- All outputs are registered.
- Reset values: tx=1, baud_en=0, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, shift register=0.
- States: IDLE, START, DATA, PARITY (only when the optional feature is compiled in), STOP.
- IDLE:
  - tx=1, baud_en=0.
  - On tx_start=1: latch tx_data into the shift register and go to START.
  - On the next edge: tx=0, baud_en=1, tx_busy=1.
  - Accept-to-line latency is 1 clk.
- START: hold tx=0 until en=1, then go to DATA and drive bit 0 of the shift register.
- DATA:
  - On each en, shift right and present the next bit.
  - Counter runs 0..DATA_BITS-1.
  - After the en that ends bit DATA_BITS-1, go to PARITY (if enabled), else STOP, with tx=1.
- STOP:
  - tx=1 for STOP_BITS en ticks.
  - On the final tick: go to IDLE; on the next edge baud_en=0, tx_busy=0, tx_done=1 for exactly one clk.
- State only advances on en ticks. Each bit lasts exactly one en interval; a 10-bit frame is 10×2604 clk.
- en while IDLE is ignored; tx stays 1.
- tx_start while busy is ignored; tx_data changes mid-frame do not affect the frame.
- tx_start in the same cycle as tx_done (state already IDLE) is accepted, giving back-to-back frames with no idle gap beyond 1 clk.
- en and tx_start in the same IDLE cycle: the start is accepted and en is ignored.
- baud_en deasserts for at least 1 clk between frames so the generator restarts its count.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). The partial frame is abandoned and no tx_done is issued.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - PARITY state is compiled in, between DATA and STOP.
  - tx carries the even-parity bit (XOR of the latched data bits) for one en interval.
  - Frame length is 1+DATA_BITS+1+STOP_BITS bits.
- When undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset: hold reset=1, toggle clk and en -> tx=1, baud_en=0, tx_busy=0, tx_done=0; release reset -> values unchanged.
- Single byte 0xA5, no parity, en every 2604 clk -> one clk after tx_start, tx and baud_en change. Line sequence at each en interval: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 10×2604 clk after accept (±1 clk); baud_en drops on the same edge.
- UART_TX_PARITY_EN, bytes 0xA5 and 0x01 -> parity bit 0 for 0xA5 and 1 for 0x01, placed before the stop bit; frame is 11 bit-times.
- Busy rejection: send 0x3C, pulse tx_start with 0xFF mid-frame -> line shows only the 0x3C frame; the 0xFF is never sent and only one tx_done pulse occurs.
- Back-to-back: assert tx_start with 0x55 in the tx_done cycle of the preceding 0x0F frame -> the second start bit begins 1 clk later; both frames decode correctly.
- Reset mid-frame: assert reset during data bit 3 of 0x81 -> tx=1 and baud_en=0 asynchronously with no tx_done; a new 0x81 after release transmits correctly.
